// File: rtl/axis_frame_length_filter.sv
// AXI-Stream frame length filter: counts beats per frame, truncates frames at
// length_max, flags undersize/truncated frames on tuser and emits per-frame status.
module axis_frame_length_filter #(
  parameter int   DATA_WIDTH           = 8,
  parameter int   LEN_WIDTH            = 16,
  parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid,
  output logic                  error_undersize,
  output logic                  error_oversize
);

  typedef enum logic {
    TRANSFER = 1'b0,
    DROP     = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [LEN_WIDTH-1:0]  count_reg, count_next;
  logic [LEN_WIDTH-1:0]  min_reg, min_next;
  logic [LEN_WIDTH-1:0]  max_reg, max_next;

  logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
  logic                  tvalid_reg, tvalid_next;
  logic                  tlast_reg, tlast_next;
  logic                  tuser_reg, tuser_next;

  logic [LEN_WIDTH-1:0]  frame_len_reg, frame_len_next;
  logic                  frame_len_valid_reg, frame_len_valid_next;
  logic                  undersize_reg, undersize_next;
  logic                  oversize_reg, oversize_next;

  logic                  accept;
  logic                  first_beat;
  logic [LEN_WIDTH-1:0]  beat_n;
  logic [LEN_WIDTH-1:0]  lim_min;
  logic [LEN_WIDTH-1:0]  lim_max;
  logic                  undersize;
  logic                  truncate;

  // Ready depends only on state and the output register, never on tvalid.
  assign input_axis_tready = (state_reg == DROP) || output_axis_tready || !tvalid_reg;
  assign accept            = input_axis_tvalid && input_axis_tready;

  // On beat 1 the live limits apply; afterwards the values latched at beat 1.
  assign first_beat = (count_reg == '0);
  assign lim_min    = first_beat ? length_min : min_reg;
  assign lim_max    = first_beat ? length_max : max_reg;

  // Counter saturates at all-ones when no limit stops a runaway frame.
  assign beat_n = (&count_reg) ? count_reg : count_reg + LEN_WIDTH'(1);

  assign undersize = input_axis_tlast && (lim_min != '0) && (beat_n < lim_min);
  assign truncate  = !input_axis_tlast && (lim_max != '0) && (beat_n == lim_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= TRANSFER;
      count_reg           <= '0;
      min_reg             <= '0;
      max_reg             <= '0;
      tdata_reg           <= '0;
      tvalid_reg          <= 1'b0;
      tlast_reg           <= 1'b0;
      tuser_reg           <= 1'b0;
      frame_len_reg       <= '0;
      frame_len_valid_reg <= 1'b0;
      undersize_reg       <= 1'b0;
      oversize_reg        <= 1'b0;
    end else begin
      state_reg           <= state_next;
      count_reg           <= count_next;
      min_reg             <= min_next;
      max_reg             <= max_next;
      tdata_reg           <= tdata_next;
      tvalid_reg          <= tvalid_next;
      tlast_reg           <= tlast_next;
      tuser_reg           <= tuser_next;
      frame_len_reg       <= frame_len_next;
      frame_len_valid_reg <= frame_len_valid_next;
      undersize_reg       <= undersize_next;
      oversize_reg        <= oversize_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    count_next           = count_reg;
    min_next             = min_reg;
    max_next             = max_reg;
    tdata_next           = tdata_reg;
    tvalid_next          = tvalid_reg && !output_axis_tready;
    tlast_next           = tlast_reg;
    tuser_next           = tuser_reg;
    frame_len_next       = frame_len_reg;
    frame_len_valid_next = 1'b0;
    undersize_next       = 1'b0;
    oversize_next        = 1'b0;

    case (state_reg)
      TRANSFER: begin
        if (accept) begin
          if (first_beat) begin
            min_next = length_min;
            max_next = length_max;
          end
          tdata_next  = input_axis_tdata;
          tvalid_next = 1'b1;
          tlast_next  = input_axis_tlast || truncate;
          count_next  = beat_n;
          if (input_axis_tlast) begin
            tuser_next           = input_axis_tuser || undersize;
            count_next           = '0;
            frame_len_next       = beat_n;
            frame_len_valid_next = 1'b1;
            undersize_next       = undersize;
          end else if (truncate) begin
            tuser_next           = USER_BAD_FRAME_VALUE;
            frame_len_next       = beat_n;
            frame_len_valid_next = 1'b1;
            oversize_next        = 1'b1;
            state_next           = DROP;
          end else begin
            tuser_next = input_axis_tuser;
          end
        end
      end
      DROP: begin
        // Remainder of a truncated frame is swallowed without touching the output.
        if (accept && input_axis_tlast) begin
          count_next = '0;
          state_next = TRANSFER;
        end
      end
      default: begin
        state_next = TRANSFER;
      end
    endcase
  end

  assign output_axis_tdata  = tdata_reg;
  assign output_axis_tvalid = tvalid_reg;
  assign output_axis_tlast  = tlast_reg;
  assign output_axis_tuser  = tuser_reg;
  assign frame_len          = frame_len_reg;
  assign frame_len_valid    = frame_len_valid_reg;
  assign error_undersize    = undersize_reg;
  assign error_oversize     = oversize_reg;

endmodule

// File: doc/axis_frame_length_filter.md
Name: axis_frame_length_filter

Overview:
Upstream stage feeding axis_frame_fifo. It counts the beats of each AXI-Stream frame, truncates oversize frames and marks undersize or truncated frames bad on tuser, so the frame FIFO can discard them. It has one registered pipeline stage and per-frame status pulses for the statistics block.

Parameters:
DATA_WIDTH, 8, width of tdata
LEN_WIDTH, 16, width of beat counter and length limits
USER_BAD_FRAME_VALUE, 1'b1, tuser value driven on the last beat of a bad frame

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
input_axis_tdata  input  DATA_WIDTH  input data
input_axis_tvalid  input  1  input valid
input_axis_tready  output  1  input ready
input_axis_tlast  input  1  input end of frame
input_axis_tuser  input  1  input bad-frame flag
output_axis_tdata  output  DATA_WIDTH  output data
output_axis_tvalid  output  1  output valid
output_axis_tready  input  1  output ready
output_axis_tlast  output  1  output end of frame
output_axis_tuser  output  1  output bad-frame flag (meaningful on the last beat)
length_min  input  LEN_WIDTH  minimum legal frame length in beats; 0 disables the check
length_max  input  LEN_WIDTH  maximum legal frame length in beats; 0 disables the check
frame_len  output  LEN_WIDTH  length of the frame just emitted (beats sent downstream)
frame_len_valid  output  1  one-cycle pulse, frame_len valid
error_undersize  output  1  one-cycle pulse: frame shorter than length_min
error_oversize  output  1  one-cycle pulse: frame truncated at length_max

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: output_axis_tvalid/tlast/tuser/tdata = 0; frame_len = 0; all pulses = 0; beat counter = 0; state = TRANSFER. Reset mid-frame abandons the frame, and the next beat counts as beat 1.
- Output register: single stage, latency 1 cycle from input accept to output_axis_tvalid.
- Input ready:
  - In TRANSFER, input_axis_tready = output_axis_tready || !output_axis_tvalid.
  - In DROP, input_axis_tready = 1.
  - input_axis_tready has no combinational dependence on input_axis_tvalid.
- Output register hold: once set, output_axis_tvalid and the data/last/user fields hold stable until output_axis_tready is high.
- Limit latching: length_min and length_max are latched when beat 1 of a frame is accepted. Changes mid-frame have no effect until the next frame.
- Beat counting: n = beat index of the accepted beat, counter + 1. LEN_WIDTH arithmetic. When length_max = 0 and no tlast arrives, the counter saturates at all-ones.
- State TRANSFER, accepted beat n:
  - Normal case: forward tdata/tlast unchanged. tuser = input_axis_tuser on non-last beats.
  - Truncation: if length_max != 0, n == length_max and input tlast = 0, then:
    - forward the beat with tlast = 1 and tuser = USER_BAD_FRAME_VALUE;
    - pulse error_oversize;
    - go to DROP.
  - Last beat: if tlast = 1, then:
    - tuser = input_axis_tuser OR (length_min != 0 && n < length_min);
    - pulse error_undersize when the undersize condition holds;
    - reset the counter.
  - A beat with tlast = 1 and n == length_max is legal; there is no truncation.
- State DROP: accept and discard beats with no output. When a beat with tlast = 1 is accepted, reset the counter and return to TRANSFER.
- Status timing:
  - frame_len_valid pulses in the same cycle the terminating beat enters the output register, whether it ends by tlast or by truncation.
  - frame_len = n, i.e. the beats forwarded downstream.
  - error_* pulses are coincident with frame_len_valid.
- Single-beat frame (n = 1, tlast = 1):
  - undersize check applies if length_min > 1;
  - length_max = 1 passes it unmodified.
- Backpressure: when output_axis_tready is low, throughput stalls and no beats are lost. In DROP, input is consumed regardless of output_axis_tready.

Test Plan:
1. length_min = 2, length_max = 4; frame of 3 beats, data 1,2,3, with tlast on 3 → output 1,2,3, tlast on 3, tuser = 0; frame_len = 3 pulse; no errors.
2. length_min = 0, length_max = 4; 6-beat frame, data 1..6 → output 1..4, tlast + tuser = 1 on beat 4; error_oversize pulse; frame_len = 4; beats 5,6 consumed with input_axis_tready = 1; the next frame passes normally.
3. length_min = 3; 1-beat frame, data 9, with tlast → output 9, tlast = 1, tuser = 1; error_undersize pulse; frame_len = 1.
4. Exact max: length_max = 4; 4-beat frame with tlast on beat 4 → tuser = 0, no error_oversize, state stays TRANSFER.
5. Backpressure: output_axis_tready toggling 1,0,0,1 during a 4-beat frame → all beats delivered in order; no output field changes while tvalid && !tready; input_axis_tready low while the output register is full and stalled.
6. Reset mid-frame: assert rst for 1 cycle after 2 beats of a frame while in DROP → output_axis_tvalid = 0 next cycle, state TRANSFER; a following 2-beat frame reports frame_len = 2 with no error.
